// File: rtl/seg7_scan_ctrl_if.sv
// Bundle for the 8-digit 7-segment scan controller.
// The master side drives the display value; the slave side drives the scan words toward the 595 stage.
interface seg7_scan_ctrl_if;
  logic [31:0] Disp_Data;
  logic [7:0]  Dp_Mask;
  logic        Blank_LZ;
  logic [7:0]  Digit_En;
  logic        Disp_Load;
  logic [15:0] Data;
  logic        S_EN;
  logic [2:0]  Digit_Idx;
  logic        Frame_Done;

  modport master (
    output Disp_Data, Dp_Mask, Blank_LZ, Digit_En, Disp_Load,
    input  Data, S_EN, Digit_Idx, Frame_Done
  );

  modport slave (
    input  Disp_Data, Dp_Mask, Blank_LZ, Digit_En, Disp_Load,
    output Data, S_EN, Digit_Idx, Frame_Done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Scans an 8-digit hex value across a multiplexed 7-segment display, one digit per slot.
// Display updates are double-buffered and take effect only when the scan wraps back to digit 0.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_CNT_MAX = 50000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(SCAN_CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CNT_MAX - 1);

  // Active-low segment pattern for a hex nibble, returned without the dp bit.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CW-1:0] scan_cnt_r;
  logic [2:0]    idx_r;
  logic [31:0]   stg_data_r;
  logic [7:0]    stg_dp_r;
  logic          stg_lz_r;
  logic          pending_r;
  logic [31:0]   act_data_r;
  logic [7:0]    act_dp_r;
  logic          act_lz_r;

  logic          tick_s;
  logic          wrap_s;
  logic [2:0]    idx_next_s;
  logic [31:0]   act_data_s;
  logic [7:0]    act_dp_s;
  logic          act_lz_s;
  logic [3:0]    nib_s;
  logic          blank_s;
  logic [7:0]    seg_s;
  logic [7:0]    sel_s;

  assign tick_s     = (scan_cnt_r == CNT_LAST);
  assign idx_next_s = idx_r + 3'd1;
  assign wrap_s     = tick_s && (idx_r == 3'd7);

  // Frame-boundary view of the display registers: a load coinciding with the wrap bypasses staging.
  always_comb begin
    act_data_s = act_data_r;
    act_dp_s   = act_dp_r;
    act_lz_s   = act_lz_r;
    if (wrap_s) begin
      if (bus.Disp_Load) begin
        act_data_s = bus.Disp_Data;
        act_dp_s   = bus.Dp_Mask;
        act_lz_s   = bus.Blank_LZ;
      end else if (pending_r) begin
        act_data_s = stg_data_r;
        act_dp_s   = stg_dp_r;
        act_lz_s   = stg_lz_r;
      end else begin
        act_data_s = act_data_r;
      end
    end else begin
      act_data_s = act_data_r;
    end
  end

  // Segment word for the digit about to be shown; computed from the post-wrap contents.
  always_comb begin
    nib_s   = act_data_s[{idx_next_s, 2'b00} +: 4];
    sel_s   = 8'h01 << idx_next_s;
    blank_s = 1'b0;
    if (!bus.Digit_En[idx_next_s]) begin
      blank_s = 1'b1;
    end else if (act_lz_s && (idx_next_s != 3'd0)
                 && ((act_data_s >> {idx_next_s, 2'b00}) == 32'd0)) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
    if (blank_s) begin
      seg_s = 8'hFF;
    end else begin
      seg_s = {~act_dp_s[idx_next_s], seg_decode(nib_s)};
    end
  end

  // Scan timer, digit sequencing, frame buffering and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scan_cnt_r     <= '0;
      idx_r          <= 3'd7;
      stg_data_r     <= 32'd0;
      stg_dp_r       <= 8'd0;
      stg_lz_r       <= 1'b0;
      pending_r      <= 1'b0;
      act_data_r     <= 32'd0;
      act_dp_r       <= 8'd0;
      act_lz_r       <= 1'b0;
      bus.Data       <= 16'h00FF;
      bus.S_EN       <= 1'b0;
      bus.Digit_Idx  <= 3'd7;
      bus.Frame_Done <= 1'b0;
    end else begin
      scan_cnt_r     <= tick_s ? '0 : scan_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      act_data_r     <= act_data_s;
      act_dp_r       <= act_dp_s;
      act_lz_r       <= act_lz_s;
      bus.S_EN       <= tick_s;
      bus.Frame_Done <= tick_s && (idx_next_s == 3'd7);
      if (bus.Disp_Load) begin
        stg_data_r <= bus.Disp_Data;
        stg_dp_r   <= bus.Dp_Mask;
        stg_lz_r   <= bus.Blank_LZ;
      end else begin
        stg_data_r <= stg_data_r;
      end
      if (wrap_s) begin
        pending_r <= 1'b0;
      end else if (bus.Disp_Load) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (tick_s) begin
        idx_r         <= idx_next_s;
        bus.Data      <= {sel_s, seg_s};
        bus.Digit_Idx <= idx_next_s;
      end else begin
        idx_r         <= idx_r;
      end
    end
  end

endmodule
